simon_sequencer: RTL and testbench

//  Parametrised Simon Says game engine: grows a pseudo-random colour sequence,

---
 rtl/simon_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_simon_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/simon_sequencer.sv
// Simon Says engine: grows an LFSR colour sequence, plays it on lamps, then checks key presses.
// Build option: define SIMON_TIMEOUT_EN to make USER inactivity end the game as a loss.
module simon_sequencer #(
  parameter int          NUM_COLORS     = 4,
  parameter int          MAX_LEN        = 32,
  parameter int          LEN_W          = 6,
  parameter int          SHOW_CYCLES    = 25_000_000,
  parameter int          GAP_CYCLES     = 12_500_000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          TIMEOUT_CYCLES = 250_000_000
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [2:0]            level,
  input  logic [NUM_COLORS-1:0] key_pulse,
  output logic [NUM_COLORS-1:0] lamp,
  output logic [1:0]            state,
  output logic [LEN_W-1:0]      score,
  output logic                  win,
  output logic                  lose,
  output logic [2:0]            dbg_fsm
);

  localparam int CW = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1;
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = 32;
  localparam logic [TW-1:0]    GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0]    SHOW_BASE = TW'(SHOW_CYCLES);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
`ifdef SIMON_TIMEOUT_EN
  localparam logic [TW-1:0]    IDLE_LOAD = TW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_READY, S_ADD, S_PLAY_ON, S_PLAY_OFF, S_USER, S_PAUSE, S_WIN, S_LOSE
  } fsm_t;

  fsm_t                  fsm_q, fsm_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      idx_q, idx_d;
  logic [LEN_W-1:0]      score_q, score_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [TW-1:0]         show_q, show_d;
  logic [15:0]           lfsr_q;
  logic [CW-1:0]         mem_q [MAX_LEN];
  logic                  mem_we;

  logic [2:0]            lvl_eff;
  logic [TW-1:0]         show_calc;
  logic [CW-1:0]         new_color;
  logic [CW-1:0]         cur_color;
  logic [NUM_COLORS-1:0] cur_onehot;
  logic                  last_idx;

  always_comb begin
    lvl_eff    = (level == 3'd0 || level > 3'd5) ? 3'd1 : level;
    show_calc  = SHOW_BASE >> (lvl_eff - 3'd1);
    if (show_calc == '0) show_calc = TW'(1);
    new_color  = CW'({24'd0, lfsr_q[7:0]} % NUM_COLORS);
    cur_color  = mem_q[idx_q[AW-1:0]];
    cur_onehot = NUM_COLORS'(1) << cur_color;
    last_idx   = (idx_q == len_q - LEN_W'(1));
  end

  always_comb begin
    fsm_d   = fsm_q;
    len_d   = len_q;
    idx_d   = idx_q;
    score_d = score_q;
    timer_d = timer_q;
    show_d  = show_q;
    mem_we  = 1'b0;
    lamp    = '0;
    case (fsm_q)
      S_READY, S_WIN, S_LOSE: begin
        if (start) begin
          len_d   = '0;
          idx_d   = '0;
          score_d = '0;
          fsm_d   = S_ADD;
        end
      end
      S_ADD: begin
        mem_we  = 1'b1;
        len_d   = len_q + LEN_W'(1);
        idx_d   = '0;
        show_d  = show_calc;
        timer_d = show_calc - TW'(1);
        fsm_d   = S_PLAY_ON;
      end
      S_PLAY_ON: begin
        lamp = cur_onehot;
        if (timer_q == '0) begin
          timer_d = GAP_LOAD;
          fsm_d   = S_PLAY_OFF;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_PLAY_OFF: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (last_idx) begin
          idx_d = '0;
          fsm_d = S_USER;
`ifdef SIMON_TIMEOUT_EN
          timer_d = IDLE_LOAD;
`endif
        end else begin
          idx_d   = idx_q + LEN_W'(1);
          timer_d = show_q - TW'(1);
          fsm_d   = S_PLAY_ON;
        end
      end
      S_USER: begin
        // Any press other than exactly the expected one-hot code is a loss.
        if (key_pulse != '0) begin
          if (key_pulse != cur_onehot) begin
            fsm_d = S_LOSE;
          end else if (!last_idx) begin
            idx_d = idx_q + LEN_W'(1);
`ifdef SIMON_TIMEOUT_EN
            timer_d = IDLE_LOAD;
`endif
          end else begin
            score_d = len_q;
            timer_d = GAP_LOAD;
            fsm_d   = (len_q == MAX_LEN_L) ? S_WIN : S_PAUSE;
          end
        end
`ifdef SIMON_TIMEOUT_EN
        else if (timer_q == '0) begin
          fsm_d = S_LOSE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
`endif
      end
      S_PAUSE: begin
        if (timer_q == '0) fsm_d = S_ADD;
        else               timer_d = timer_q - TW'(1);
      end
      default: fsm_d = S_READY;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      fsm_q   <= S_READY;
      len_q   <= '0;
      idx_q   <= '0;
      score_q <= '0;
      timer_q <= '0;
      show_q  <= '0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      fsm_q   <= fsm_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      score_q <= score_d;
      timer_q <= timer_d;
      show_q  <= show_d;
      // Free-running so the moment of start seeds the game.
      lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (mem_we) mem_q[len_q[AW-1:0]] <= new_color;
  end

  always_comb begin
    case (fsm_q)
      S_READY:       state = 2'b00;
      S_USER:        state = 2'b10;
      S_WIN, S_LOSE: state = 2'b11;
      default:       state = 2'b01;
    endcase
  end

  assign score   = score_q;
  assign win     = (fsm_q == S_WIN);
  assign lose    = (fsm_q == S_LOSE);
  assign dbg_fsm = fsm_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench for simon_sequencer: expected lamp codes queued per round, presses from a reference LFSR.
module tb_simon_sequencer;
  localparam int NC = 4;
  localparam int ML = 4;
  localparam int LW = 6;
  localparam int SH = 8;
  localparam int GP = 4;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          resetn, start;
  logic [2:0]    level;
  logic [NC-1:0] key_pulse, lamp;
  logic [1:0]    state;
  logic [LW-1:0] score;
  logic          win, lose;
  logic [2:0]    dbg_fsm;

  always #5 clk = ~clk;

  simon_sequencer #(
    .NUM_COLORS(NC), .MAX_LEN(ML), .LEN_W(LW), .SHOW_CYCLES(SH),
    .GAP_CYCLES(GP), .LFSR_SEED(16'hACE1), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .level(level),
    .key_pulse(key_pulse), .lamp(lamp), .state(state), .score(score),
    .win(win), .lose(lose), .dbg_fsm(dbg_fsm)
  );

  // Reference LFSR: Fibonacci, taps 16,14,13,11, stepping every cycle out of reset.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (!resetn) m_lfsr <= 16'hACE1;
    else         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [NC-1:0] exp_q[$];
  int         seq [0:7];
  int         cur_len;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called one step after the edge that entered ADD: DUT LFSR equals the reference here.
  task automatic do_add();
    seq[cur_len] = int'(m_lfsr[7:0]) % NC;
    cur_len++;
    check("add_state", 32'(state), 32'd1);
  endtask

  task automatic play_round(input int show, input bit inject);
    logic [NC-1:0] e;
    for (int i = 0; i < cur_len; i++) exp_q.push_back(NC'(1) << seq[i]);
    for (int i = 0; i < cur_len; i++) begin
      e = exp_q.pop_front();
      for (int c = 0; c < show; c++) begin
        if (inject && i == 0 && c == 2) key_pulse = e;
        if (inject && i == 0 && c == 4) key_pulse = 4'b1111;
        tick();
        key_pulse = '0;
        check("lamp_on", 32'(lamp), 32'(e));
      end
      for (int c = 0; c < GP; c++) begin
        tick();
        check("lamp_off", 32'(lamp), 32'd0);
      end
    end
    tick();
    check("user_state", 32'(state), 32'd2);
  endtask

  task automatic press(input logic [NC-1:0] k);
    key_pulse = k;
    tick();
    key_pulse = '0;
  endtask

  task automatic press_all();
    for (int i = 0; i < cur_len; i++) press(NC'(1) << seq[i]);
  endtask

  task automatic pause_then_add();
    repeat (GP) tick();
    do_add();
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; level = 3'd1; key_pulse = '0; cur_len = 0;
    repeat (2) tick();
    check("rst_lamp", 32'(lamp), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_winlose", {30'd0, win, lose}, 32'd0);
    resetn = 1'b1;
    press(4'b0001);
    repeat (3) tick();
    check("ready_hold", 32'(state), 32'd0);

    // Game 1: four correct rounds to a win.
    do_start();
    do_add();
    for (int r = 1; r <= ML; r++) begin
      play_round(SH, 1'b0);
      check("score_before", 32'(score), 32'(r - 1));
      press_all();
      check("score_round", 32'(score), 32'(r));
      if (r < ML) pause_then_add();
    end
    check("win_flag", 32'(win), 32'd1);
    check("win_state", 32'(state), 32'd3);

    // Game 2: wrong colour at index 1 of round 2.
    do_start();
    cur_len = 0;
    check("restart_score", 32'(score), 32'd0);
    do_add();
    play_round(SH, 1'b0);
    press_all();
    check("g2_score1", 32'(score), 32'd1);
    pause_then_add();
    play_round(SH, 1'b0);
    press(NC'(1) << seq[0]);
    press(NC'(1) << ((seq[1] + 1) % NC));
    check("wrong_lose", 32'(lose), 32'd1);
    check("wrong_state", 32'(state), 32'd3);
    check("wrong_score", 32'(score), 32'd1);

    // Game 3: presses during playback are ignored; two-bit press loses.
    do_start();
    cur_len = 0;
    check("lose_restart_score", 32'(score), 32'd0);
    check("lose_restart_state", 32'(state), 32'd1);
    do_add();
    play_round(SH, 1'b1);
    check("ignored_score", 32'(score), 32'd0);
    press_all();
    check("g3_score1", 32'(score), 32'd1);
    pause_then_add();
    play_round(SH, 1'b0);
    press(4'b0011);
    check("multi_lose", 32'(lose), 32'd1);
    check("multi_score", 32'(score), 32'd1);

    // Game 4: level 3 shortens show, level 0 sampled on the next ADD gives full length.
    level = 3'd3;
    do_start();
    cur_len = 0;
    do_add();
    play_round(SH >> 2, 1'b0);
    press_all();
    check("g4_score1", 32'(score), 32'd1);
    level = 3'd0;
    pause_then_add();
    play_round(SH, 1'b0);
    do_start();
    check("start_ignored_state", 32'(state), 32'd2);
    check("start_ignored_score", 32'(score), 32'd1);
`ifdef SIMON_TIMEOUT_EN
    repeat (TO - 2) tick();
    check("idle_before", 32'(state), 32'd2);
    tick();
    check("idle_lose", 32'(lose), 32'd1);
`else
    repeat (3 * TO) tick();
    check("idle_wait", 32'(state), 32'd2);
    check("idle_nolose", 32'(lose), 32'd0);
`endif

    // Reset aborts whatever is in progress.
    resetn = 1'b0;
    repeat (2) tick();
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_score", 32'(score), 32'd0);
    check("midrst_flags", {30'd0, win, lose}, 32'd0);
    resetn = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
